// File: rtl/lsu_dmem_master.sv
// Load/store unit driving a doubleword-indexed data memory with a combinational read port.
// Sub-doubleword stores use read-modify-write; one request is in flight at a time.
module lsu_dmem_master #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned OFFSET_BITS = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_address,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_write_data,
    input  logic [XLEN-1:0] mem_read_data
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StWrite  = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    localparam int unsigned ShW = OFFSET_BITS + 3;

    logic [1:0]             state_q, state_d;
    logic                   write_q;
    logic [2:0]             funct3_q;
    logic [OFFSET_BITS-1:0] off_q;
    logic [XLEN-1:0]        mem_address_q;
    logic [XLEN-1:0]        mem_wdata_q;
    logic [XLEN-1:0]        resp_rdata_q;
    logic                   resp_fault_q;

    logic [ShW-1:0]  shamt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN-1:0] merged;
    logic            misaligned;
    logic            fault;
    logic            store_d;
    logic            need_rmw;

    assign shamt   = {off_q, 3'b000};
    assign shifted = mem_read_data >> shamt;
    assign store_d = write_q && (funct3_q == 3'b011);

    always_comb begin
        misaligned = 1'b0;
        case (funct3_q[1:0])
            2'b01:   misaligned = off_q[0];
            2'b10:   misaligned = off_q[1:0] != 2'b00;
            2'b11:   misaligned = off_q != '0;
            default: misaligned = 1'b0;
        endcase
    end

    assign fault    = misaligned || (funct3_q == 3'b111) || (write_q && funct3_q[2]);
    assign need_rmw = !fault && write_q && !store_d;

    always_comb begin
        load_data = '0;
        case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b011:  load_data = shifted;
            3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            3'b110:  load_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        lane_mask = '1;
        case (funct3_q[1:0])
            2'b00:   lane_mask = XLEN'(8'hFF);
            2'b01:   lane_mask = XLEN'(16'hFFFF);
            2'b10:   lane_mask = XLEN'(32'hFFFF_FFFF);
            default: lane_mask = '1;
        endcase
    end

    // mem_wdata_q still holds the store data from the handshake while in ACCESS.
    assign merged = (mem_read_data & ~(lane_mask << shamt))
                  | ((mem_wdata_q << shamt) & (lane_mask << shamt));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (req_valid) state_d = StAccess;
            StAccess: state_d = need_rmw ? StWrite : StResp;
            StWrite:  state_d = StResp;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            write_q       <= 1'b0;
            funct3_q      <= 3'b000;
            off_q         <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            resp_rdata_q  <= '0;
            resp_fault_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req_valid) begin
                write_q       <= req_write;
                funct3_q      <= req_funct3;
                off_q         <= req_addr[OFFSET_BITS-1:0];
                mem_address_q <= req_addr >> OFFSET_BITS;
                if (req_write) mem_wdata_q <= req_wdata;
            end
            if (state_q == StAccess) begin
                resp_fault_q <= fault;
                resp_rdata_q <= (!fault && !write_q) ? load_data : '0;
                if (need_rmw) mem_wdata_q <= merged;
            end
        end
    end

    assign req_ready      = state_q == StIdle;
    assign resp_valid     = state_q == StResp;
    assign resp_rdata     = resp_rdata_q;
    assign resp_fault     = resp_fault_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_wdata_q;
    assign mem_write      = (state_q == StWrite) || (state_q == StAccess && !fault && store_d);

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Bench for lsu_dmem_master: vector table plus response scoreboard and a mid-access reset case.
module tb_lsu_dmem_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [63:0] mem_address;
    logic        mem_write;
    logic [63:0] mem_write_data;
    logic [63:0] mem_read_data;

    lsu_dmem_master #(.XLEN(64), .OFFSET_BITS(3)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .mem_address    (mem_address),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:7];
    assign mem_read_data = mem[mem_address[2:0]];
    always @(posedge clk) if (mem_write) mem[mem_address[2:0]] <= mem_write_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        fault;
        int          lat;
        int          writes;
        logic [63:0] wd_exp;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        fault;
        int          hs;
        int          lat;
        int          writes;
        logic [63:0] wd_exp;
        logic [63:0] maddr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   wr_cnt = 0;

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset_n && mem_write) begin
            if (sb.size() == 0) begin
                chk("unexpected_mem_write", 64'(mem_write), 64'd0);
            end else begin
                chk("write_cycle", 64'(cyc), 64'(sb[0].hs + sb[0].lat - 1));
                chk("write_data", mem_write_data, sb[0].wd_exp);
                chk("write_addr", mem_address, sb[0].maddr);
                wr_cnt++;
            end
        end
        if (reset_n && resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_fault", 64'(resp_fault), 64'(e.fault));
                chk("resp_cycle", 64'(cyc), 64'(e.hs + e.lat));
                chk("resp_addr", mem_address, e.maddr);
                chk("write_count", 64'(wr_cnt), 64'(e.writes));
                wr_cnt = 0;
            end
        end
    end

    task automatic issue(input vec_t v);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("req_ready_before_issue", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        e.rdata  = v.rdata;
        e.fault  = v.fault;
        e.hs     = cyc;
        e.lat    = v.lat;
        e.writes = v.writes;
        e.wd_exp = v.wd_exp;
        e.maddr  = v.addr >> 3;
        wr_cnt = 0;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (sb.size() != 0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("resp_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    logic [63:0] snap2;
    logic        saw_bad;
    vec_t        sbv;

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        mem[2] = 64'h8877665544332211;

        //                wr    f3      addr      wdata                  rdata                  flt lat w  wd_exp
        vecs.push_back('{1'b0, 3'b000, 64'h17, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0, 2, 0, 64'h0});
        vecs.push_back('{1'b0, 3'b101, 64'h16, 64'h0, 64'h0000000000008877, 1'b0, 2, 0, 64'h0});
        vecs.push_back('{1'b0, 3'b010, 64'h14, 64'h0, 64'hFFFFFFFF88776655, 1'b0, 2, 0, 64'h0});
        vecs.push_back('{1'b0, 3'b011, 64'h10, 64'h0, 64'h8877665544332211, 1'b0, 2, 0, 64'h0});
        vecs.push_back('{1'b0, 3'b100, 64'h11, 64'h0, 64'h0000000000000022, 1'b0, 2, 0, 64'h0});
        vecs.push_back('{1'b0, 3'b001, 64'h10, 64'h0, 64'h0000000000002211, 1'b0, 2, 0, 64'h0});
        vecs.push_back('{1'b0, 3'b110, 64'h14, 64'h0, 64'h0000000088776655, 1'b0, 2, 0, 64'h0});
        vecs.push_back('{1'b1, 3'b001, 64'h12, 64'h111122223333ABCD, 64'h0, 1'b0, 3, 1,
                         64'h88776655ABCD2211});
        vecs.push_back('{1'b0, 3'b011, 64'h10, 64'h0, 64'h88776655ABCD2211, 1'b0, 2, 0, 64'h0});
        vecs.push_back('{1'b1, 3'b011, 64'h18, 64'h0123456789ABCDEF, 64'h0, 1'b0, 2, 1,
                         64'h0123456789ABCDEF});
        vecs.push_back('{1'b0, 3'b011, 64'h18, 64'h0, 64'h0123456789ABCDEF, 1'b0, 2, 0, 64'h0});
        vecs.push_back('{1'b1, 3'b000, 64'h1F, 64'h777777777777775A, 64'h0, 1'b0, 3, 1,
                         64'h5A23456789ABCDEF});
        vecs.push_back('{1'b1, 3'b010, 64'h1C, 64'h00000000DEADBEEF, 64'h0, 1'b0, 3, 1,
                         64'hDEADBEEF89ABCDEF});
        vecs.push_back('{1'b0, 3'b000, 64'h18, 64'h0, 64'hFFFFFFFFFFFFFFEF, 1'b0, 2, 0, 64'h0});
        vecs.push_back('{1'b0, 3'b010, 64'h12, 64'h0, 64'h0, 1'b1, 2, 0, 64'h0});
        vecs.push_back('{1'b1, 3'b001, 64'h11, 64'hFFFF, 64'h0, 1'b1, 2, 0, 64'h0});
        vecs.push_back('{1'b1, 3'b100, 64'h10, 64'hFF, 64'h0, 1'b1, 2, 0, 64'h0});
        vecs.push_back('{1'b0, 3'b111, 64'h10, 64'h0, 64'h0, 1'b1, 2, 0, 64'h0});
        vecs.push_back('{1'b0, 3'b011, 64'h11, 64'h0, 64'h0, 1'b1, 2, 0, 64'h0});
        vecs.push_back('{1'b0, 3'b011, 64'h10, 64'h0, 64'h88776655ABCD2211, 1'b0, 2, 0, 64'h0});

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_fault", 64'(resp_fault), 64'd0);
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_mem_address", mem_address, 64'd0);
        chk("rst_mem_write_data", mem_write_data, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        foreach (vecs[i]) issue(vecs[i]);

        chk("mem2_after_faults", mem[2], 64'h88776655ABCD2211);
        chk("mem3_final", mem[3], 64'hDEADBEEF89ABCDEF);

        // Reset during the ACCESS cycle of an SB: no write, no response.
        snap2   = mem[2];
        saw_bad = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 64'h13;
        req_wdata  = 64'h00;
        @(negedge clk);
        req_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("abort_mem_write_low", 64'(mem_write), 64'd0);
        chk("abort_req_ready_in_reset", 64'(req_ready), 64'd1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            if (mem_write || resp_valid) saw_bad = 1'b1;
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (mem_write || resp_valid) saw_bad = 1'b1;
        end
        chk("abort_no_write_or_resp", 64'(saw_bad), 64'd0);
        chk("abort_mem_unchanged", mem[2], snap2);
        chk("abort_req_ready_after", 64'(req_ready), 64'd1);

        // The unit must be usable again after the aborted request.
        sbv = '{1'b0, 3'b100, 64'h13, 64'h0, 64'h00000000000000AB, 1'b0, 2, 0, 64'h0};
        issue(sbv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
Load/store unit that acts as the requesting side of the data-memory port. The memory has a doubleword-indexed address, a combinational read and a write on the clock edge.
- Accepts one byte-addressed RV64 load/store per handshake from the core.
- Translates it to doubleword memory accesses, using read-modify-write for sub-doubleword stores.
- Returns the extracted and extended load data, or a fault, as a one-cycle response pulse.

Parameters:
XLEN, 64, data and address width
OFFSET_BITS, 3, log2 of bytes per memory word; mem_address = req_addr >> OFFSET_BITS

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous reset, active low
req_valid  input  1  core presents a request
req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV64 width/sign code (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU)
req_addr  input  64  byte address
req_wdata  input  64  store data; only the low bytes are used
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  64  load result; 0 for stores and faults
resp_fault  output  1  valid with resp_valid: misaligned or illegal funct3
mem_address  output  64  doubleword index to the data memory
mem_write  output  1  memory write enable
mem_write_data  output  64  memory write data
mem_read_data  input  64  combinational memory read data for mem_address

Behaviour:
- States: IDLE, ACCESS, WRITE, RESP. Reset forces IDLE asynchronously.
- Reset values: resp_valid=0, resp_rdata=0, resp_fault=0, mem_write=0, mem_address=0, mem_write_data=0. req_ready=1 once reset is released.
- IDLE: req_ready=1. On handshake, register write, funct3, addr and wdata, then go to ACCESS.
- ACCESS: mem_address = {3'b0, addr[63:3]}. Let off = addr[2:0].
  - Fault if the access is misaligned (H with off[0]!=0; W/WU with off[1:0]!=0; D with off!=0), if funct3==111, or if the request is a store with funct3[2]==1.
    - Fault: mem_write stays 0; set fault flag; go to RESP.
  - Load:
    - Extract the lanes from mem_read_data; byte lane k = bits [8k+7:8k], little-endian.
    - Sign-extend for B/H/W; zero-extend for BU/HU/WU; D is passed through.
    - Register the result into resp_rdata; go to RESP.
  - Store D: mem_write=1 and mem_write_data=wdata in this cycle; go to RESP.
  - Store B/H/W:
    - Register the merged word: mem_read_data with lanes off..off+size-1 replaced by the low bytes of wdata.
    - mem_write=0; go to WRITE.
- WRITE: mem_address held; mem_write=1 for exactly this cycle; mem_write_data = merged word; go to RESP.
- RESP: resp_valid=1 for one cycle with resp_rdata/resp_fault; return to IDLE. No back-pressure on the response.
- Latency from handshake cycle T:
  - load, SD, or fault: resp_valid at T+2;
  - SB/SH/SW: resp_valid at T+3.
- Throughput: at most one request in flight; a new handshake is possible in the cycle after RESP.
- mem_write is asserted at most once per request and never for a fault.
- Outside WRITE and store-D ACCESS, mem_write is 0. mem_address and mem_write_data hold their last values and are don't-care when mem_write=0.
- Reset mid-operation: state returns to IDLE and mem_write drops immediately. No partial write and no response is produced for the aborted request.
- req_valid while not in IDLE is ignored; the core must hold the request until req_ready.

Test Plan:
- Preload memory word 2 = 0x8877665544332211. LB at 0x17 -> resp_rdata=0xFFFFFFFFFFFFFF88 at T+2, resp_fault=0, mem_address=2.
- Same word: LHU at 0x16 -> 0x0000000000008877. LW at 0x14 -> 0xFFFFFFFF88776655. LD at 0x10 -> 0x8877665544332211.
- SH at 0x12, wdata=0x????????????ABCD -> mem_write high only at T+2, mem_write_data=0x88776655ABCD2211, resp_valid at T+3, resp_rdata=0.
- SD at 0x18, wdata=0x0123456789ABCDEF -> mem_write at T+1, mem_address=3, resp at T+2. A following LD at 0x18 returns 0x0123456789ABCDEF.
- Faults: LW at 0x12, SH at 0x11, and a store with funct3=100 -> resp_fault=1 at T+2, resp_rdata=0, mem_write never asserted, memory unchanged.
- Assert reset_n=0 during ACCESS of an SB -> mem_write never pulses, no resp_valid, memory unchanged; req_ready=1 after reset is released.
